dfe_axil_seq_master: RTL
========================

DFE_AXIL_SEQ_MASTER -- requirements
Module: dfe_axil_seq_master

Interface
REQ-001 SHALL have parameter C_M_TARGET_SLAVE_BASE_ADDR, default 32'h4000_0000, byte address of slave register 0.
REQ-002 SHALL have parameter C_M_TRANSACTIONS_NUM, default 4, number of registers exercised (range 1..256).
REQ-003 SHALL have parameter C_M_DATA_SEED, default 32'hA5A5_0000, base value of the write pattern.
REQ-004 SHALL have one clock and synchronous active-high reset: M_AXI_ACLK  in  1  sole clock, all logic on rising edge.
REQ-005 M_AXI_ARESET  in  1  synchronous, active-high reset.
REQ-006 INIT_TXN  in  1  start request; rising edge starts a sequence.
REQ-007 TXN_DONE  out  1  high while the sequence is complete.
REQ-008 ERROR  out  1  sticky failure flag.
REQ-009 M_AXI_AWADDR  out  32  write address.
REQ-010 M_AXI_AWPROT  out  3  constant 3'b000.
REQ-011 M_AXI_AWVALID  out  1  write address valid.
REQ-012 M_AXI_AWREADY  in  1  write address ready.
REQ-013 M_AXI_WDATA  out  32  write data.
REQ-014 M_AXI_WSTRB  out  4  constant 4'hF.
REQ-015 M_AXI_WVALID  out  1  write data valid.
REQ-016 M_AXI_WREADY  in  1  write data ready.
REQ-017 M_AXI_BRESP  in  2  write response.
REQ-018 M_AXI_BVALID  in  1  write response valid.
REQ-019 M_AXI_BREADY  out  1  write response ready.
REQ-020 M_AXI_ARADDR  out  32  read address.
REQ-021 M_AXI_ARPROT  out  3  constant 3'b000.
REQ-022 M_AXI_ARVALID  out  1  read address valid.
REQ-023 M_AXI_ARREADY  in  1  read address ready.
REQ-024 M_AXI_RDATA  in  32  read data.
REQ-025 M_AXI_RRESP  in  2  read response.
REQ-026 M_AXI_RVALID  in  1  read data valid.
REQ-027 M_AXI_RREADY  out  1  read data ready.

Function
REQ-028 SHALL implement FSM IDLE -> WRITE -> WAIT_B -> READ -> WAIT_R -> (next index: WRITE | last: DONE); DONE -> WRITE on new INIT_TXN rising edge.
REQ-029 SHALL, for index i (0..N-1), use address BASE + 4*i (32-bit wrap-around) and data C_M_DATA_SEED + i (mod 2^32).
REQ-030 SHALL assert AWVALID and WVALID in the cycle after the INIT_TXN rising edge is sampled; each holds with stable payload until its own READY is sampled high, then deasserts independently; WRITE exits only when both handshakes have completed (same or different cycles).
REQ-031 SHALL assert BREADY only in WAIT_B; ARVALID in READ until ARREADY; RREADY only in WAIT_R; exactly one transaction outstanding at any time.
REQ-032 SHALL set ERROR when a BRESP or RRESP other than 2'b00 is accepted, or on readback mismatch; ERROR clears only on a new start; the sequence always completes all N indices.
REQ-033 SHALL hold TXN_DONE high from the cycle after the last R handshake until the next start, when it drops in the same cycle AWVALID rises.
REQ-034 SHALL ignore INIT_TXN edges while in WRITE..WAIT_R; INIT_TXN held high SHALL NOT restart.

Reset
REQ-035 On M_AXI_ARESET sampled high, including mid-transaction, SHALL on that edge return to IDLE with all VALID/READY outputs, TXN_DONE, ERROR, index 0; the INIT_TXN edge detector SHALL be cleared so a level held through reset does not start.

Configuration
REQ-036 With READBACK_CHECK_EN defined, SHALL compare RDATA to the written word and flag mismatch; without it, SHALL still run the read phase but set ERROR only from BRESP/RRESP.

Structure
REQ-037 SHALL place the AXI response codes (OKAY=2'b00, EXOKAY=2'b01) and the FSM state encoding in shared package dfe_axil_pkg; no sub-module is required.

Verification
REQ-038 Defaults, slave always ready, INIT_TXN pulse -> writes 0xA5A50000..03 to 0x40000000..0C, identical readback, TXN_DONE=1, ERROR=0.
REQ-039 AWREADY delayed 3 cycles after WREADY -> AWADDR/WDATA stable, single B wait per index, same result as REQ-038.
REQ-040 BRESP=2'b10 on index 1 -> ERROR=1 sticky, all 4 indices still executed, TXN_DONE=1.
REQ-041 READBACK_CHECK_EN defined, slave returns 0xDEADBEEF on index 2 -> ERROR=1; macro undefined -> ERROR=0.
REQ-042 Reset asserted while ARVALID=1 on index 2, then new pulse -> all outputs 0 after reset edge, restart at index 0 address 0x40000000.

Source files
------------

// File: rtl/dfe_axil_pkg.sv
// Shared AXI4-Lite response codes and sequencer state encoding
// for the DFE register-sequence master.
`timescale 1ns/1ps
package dfe_axil_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_WAIT_B,
      S_READ,
      S_WAIT_R,
      S_DONE
   } state_t;

endpackage

// File: rtl/dfe_axil_seq_master.sv
// AXI4-Lite master: write N words, read each back, report done/error.
// Optional macro READBACK_CHECK_EN enables read-data comparison.
`timescale 1ns/1ps
module dfe_axil_seq_master
   import dfe_axil_pkg::*;
#(
   parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h4000_0000,
   parameter int unsigned C_M_TRANSACTIONS_NUM       = 4,
   parameter logic [31:0] C_M_DATA_SEED              = 32'hA5A5_0000
)(
   input  logic        M_AXI_ACLK,
   input  logic        M_AXI_ARESET,
   input  logic        INIT_TXN,
   output logic        TXN_DONE,
   output logic        ERROR,
   output logic [31:0] M_AXI_AWADDR,
   output logic [2:0]  M_AXI_AWPROT,
   output logic        M_AXI_AWVALID,
   input  logic        M_AXI_AWREADY,
   output logic [31:0] M_AXI_WDATA,
   output logic [3:0]  M_AXI_WSTRB,
   output logic        M_AXI_WVALID,
   input  logic        M_AXI_WREADY,
   input  logic [1:0]  M_AXI_BRESP,
   input  logic        M_AXI_BVALID,
   output logic        M_AXI_BREADY,
   output logic [31:0] M_AXI_ARADDR,
   output logic [2:0]  M_AXI_ARPROT,
   output logic        M_AXI_ARVALID,
   input  logic        M_AXI_ARREADY,
   input  logic [31:0] M_AXI_RDATA,
   input  logic [1:0]  M_AXI_RRESP,
   input  logic        M_AXI_RVALID,
   output logic        M_AXI_RREADY
);

   localparam logic [8:0] LAST = 9'(C_M_TRANSACTIONS_NUM - 1);

   state_t      state;
   state_t      state_nxt;
   logic        init_q;
   logic        start;
   logic [8:0]  idx;
   logic        aw_done;
   logic        w_done;
   logic        aw_ok;
   logic        w_ok;
   logic        err;
   logic        rd_bad;
   logic [31:0] addr;
   logic [31:0] wdata;

   assign start = INIT_TXN & ~init_q;
   assign addr  = C_M_TARGET_SLAVE_BASE_ADDR + {21'd0, idx, 2'b00};
   assign wdata = C_M_DATA_SEED + {23'd0, idx};

`ifdef READBACK_CHECK_EN
   assign rd_bad = (M_AXI_RDATA != wdata);
`else
   logic rdata_unused;
   assign rdata_unused = ^M_AXI_RDATA;
   assign rd_bad       = 1'b0;
`endif

   assign M_AXI_AWADDR  = addr;
   assign M_AXI_ARADDR  = addr;
   assign M_AXI_WDATA   = wdata;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_WSTRB   = 4'hF;
   assign M_AXI_AWVALID = (state == S_WRITE) && !aw_done;
   assign M_AXI_WVALID  = (state == S_WRITE) && !w_done;
   assign M_AXI_BREADY  = (state == S_WAIT_B);
   assign M_AXI_ARVALID = (state == S_READ);
   assign M_AXI_RREADY  = (state == S_WAIT_R);
   assign TXN_DONE      = (state == S_DONE);
   assign ERROR         = err;

   // AW and W complete independently; WRITE leaves once both have fired
   assign aw_ok = aw_done || M_AXI_AWREADY;
   assign w_ok  = w_done || M_AXI_WREADY;

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE, S_DONE: begin
            if (start) state_nxt = S_WRITE;
         end
         S_WRITE: begin
            if (aw_ok && w_ok) state_nxt = S_WAIT_B;
         end
         S_WAIT_B: begin
            if (M_AXI_BVALID) state_nxt = S_READ;
         end
         S_READ: begin
            if (M_AXI_ARREADY) state_nxt = S_WAIT_R;
         end
         S_WAIT_R: begin
            if (M_AXI_RVALID)
               state_nxt = (idx == LAST) ? S_DONE : S_WRITE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge M_AXI_ACLK) begin
      if (M_AXI_ARESET) begin
         state   <= S_IDLE;
         init_q  <= 1'b1;
         idx     <= '0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
         err     <= 1'b0;
      end else begin
         state   <= state_nxt;
         init_q  <= INIT_TXN;
         aw_done <= (state == S_WRITE) && (state_nxt == S_WRITE) && aw_ok;
         w_done  <= (state == S_WRITE) && (state_nxt == S_WRITE) && w_ok;
         if (start && (state == S_IDLE || state == S_DONE)) begin
            idx <= '0;
            err <= 1'b0;
         end
         if (state == S_WAIT_B && M_AXI_BVALID && M_AXI_BRESP != RESP_OKAY)
            err <= 1'b1;
         if (state == S_WAIT_R && M_AXI_RVALID) begin
            if (M_AXI_RRESP != RESP_OKAY || rd_bad) err <= 1'b1;
            if (idx != LAST) idx <= idx + 9'd1;
         end
      end
   end

endmodule
